ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage between the program counter and the decoder. It takes the current address from `pc` (`pc_out`), fetches the instruction word from instruction memory over a req/ack handshake, and pulses `pc_adv` so the PC advances. Fetched words go into a small tagged FIFO, each paired with its address, which the decoder drains over a valid/ready handshake. `flush_in` (taken branch, jump or return) discards all buffered and in-flight fetches.

## Interface
- `DEPTH`, 2, number of instruction buffer entries; must be a power of 2 and ≥ 2.
- `clk` in 1: system clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pc_in` in 16: next fetch address, driven from `pc_out`.
- `pc_adv` out 1: one-cycle pulse meaning a fetch of `pc_in` was launched; the PC selects its increment path.
- `flush_in` in 1: redirect; kill buffered and outstanding fetches.
- `imem_req` out 1: memory request.
- `imem_addr` out 16: request address, stable while `imem_req`=1.
- `imem_ack` in 1: memory response valid; the request completes.
- `imem_rdata` in 16: instruction word, valid with `imem_ack`.
- `ins_out` out 16: head instruction; 16'h0000 (NOP) when empty.
- `ins_pc_out` out 16: address of head instruction; 16'h0000 when empty.
- `ins_valid` out 1: FIFO non-empty.
- `ins_ready` in 1: decoder accepts the head this cycle.

## Operation
- FSM states:
  - `IDLE`: no request outstanding.
  - `REQ`: request outstanding, response kept.
  - `DRAIN`: request outstanding, response discarded.
- `IDLE` → `REQ` when `count` < `DEPTH` and `flush_in`=0. At that edge:
  - `imem_addr` ← `pc_in`.
  - `imem_req` ← 1.
  - `pc_adv` ← 1 for exactly one cycle.
- `REQ` with `imem_ack`=1 and `flush_in`=0:
  - Push {`imem_addr`, `imem_rdata`}.
  - `imem_req` ← 0, go to `IDLE`.
- `REQ` with `flush_in`=1 and `imem_ack`=0: go to `DRAIN`; `imem_req` stays 1 until ack, as the protocol requires.
- `REQ` with `flush_in`=1 and `imem_ack`=1: discard the data, `imem_req` ← 0, go to `IDLE`.
- `DRAIN` with `imem_ack`=1: discard the data, `imem_req` ← 0, go to `IDLE`. A flush while in `DRAIN` has no extra effect.
- `imem_ack` while in `IDLE` is ignored.
- Flush priority and effects:
  - Flush clears the FIFO: count, read and write pointers go to 0.
  - Flush overrides push, pop and launch in the same cycle.
  - No `pc_adv` pulse in a flush cycle.
- Pop happens when `ins_valid` and `ins_ready` are both 1. Pop and push in the same cycle are both performed; `count` is unchanged.
- Overflow cannot occur: a launch requires a free slot, only one request is ever outstanding, and `count` only falls while waiting.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is `$clog2(DEPTH)+1` bits.
- `imem_addr` carries 16'hFFFF unchanged; the wrap to 0 is the PC's job.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `pc_adv`=0, `ins_valid`=0, `ins_out`=0, `ins_pc_out`=0, FSM=`IDLE`, `count`=0.
- Reset is asserted asynchronously and released synchronously to `clk`. Reset in the middle of a request abandons it; the memory shares `rst`.
- First launch: `imem_req` and `pc_adv` go high in the first cycle after `rst` deasserts.
- Request issued in cycle n, ack in cycle n+k (k ≥ 0):
  - `ins_valid` is high in cycle n+k+1.
  - The next request is in cycle n+k+2 if a slot is free.
  - Peak throughput is one instruction per 2 cycles.
- All outputs are registered, except `ins_out`, `ins_pc_out` and `ins_valid`, which decode FIFO head state (flops only, no input-to-output paths).

## Structure
- Add `ifetch_state_t` (`IDLE`, `REQ`, `DRAIN`) and `INS_NOP` = 16'h0000 to `mycpu_pkg`.
- Sub-module `ifetch_fifo`: DEPTH × 32-bit storage ({pc, ins}), push/pop/clear, `count`, head outputs.
- `ifetch` holds the FSM and the memory-side registers.

## Test plan
- Reset then a memory with ack the same cycle as the request (k=0), `pc_in`=16'h0010 → `imem_addr`=16'h0010 and one `pc_adv` pulse. `ins_out`=`imem_rdata`, `ins_pc_out`=16'h0010, and `ins_valid` rises 1 cycle after the ack.
- `ins_ready`=0 with k=0 → exactly `DEPTH`=2 launches. With the FIFO full, `imem_req` stays 0 and no `pc_adv`. Raising `ins_ready` pops in order and restarts fetch.
- k=3 latency and `flush_in` pulse while in `REQ` → FSM goes to `DRAIN`, `imem_req` is held until ack, the data is dropped, and `ins_valid` stays 0. The next fetch uses the new `pc_in`=16'h0200.
- `flush_in` in the same cycle as `imem_ack` with 1 entry buffered → FIFO empty, no push, next cycle `IDLE`, no `pc_adv` in the flush cycle.
- Simultaneous push and pop at `count`=1 → `count` stays 1 and the head is the new entry. Check FIFO order across pointer wrap over 6 fetches, addresses 16'hFFFE, 16'hFFFF, 16'h0000, and so on.
- Assert `rst` asynchronously mid-`REQ` → all outputs take their reset values immediately. A late `imem_ack` arriving in `IDLE` is ignored.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared CPU types and constants used by the instruction fetch stage.
package mycpu_pkg;

    localparam int ADDR_W = 16;
    localparam int INS_W  = 16;

    // Instruction presented to the decoder when nothing is buffered.
    localparam logic [INS_W-1:0] INS_NOP = 16'h0000;

    // Fetch controller states:
    //   IDLE  - no memory request outstanding
    //   REQ   - request outstanding, the response will be buffered
    //   DRAIN - request outstanding, the response will be dropped (redirected)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small instruction buffer: each entry pairs a fetched word with its address.
// Clear has priority over push and pop; the head reads as NOP/0 when empty.
module ifetch_fifo
    import mycpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INS_W-1:0]  push_ins,
    output logic [CNT_W-1:0]  count,
    output logic [INS_W-1:0]  head_ins,
    output logic [ADDR_W-1:0] head_pc,
    output logic              head_valid
);

    logic [ADDR_W+INS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign do_push = push && !clear && (count != CNT_W'(DEPTH));
    assign do_pop  = pop  && !clear && (count != '0);

    // Pointer and occupancy bookkeeping; a clear empties the buffer outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are not reset because the head is masked by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_pc, push_ins};
    end

    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? mem[rd_ptr][ADDR_W+INS_W-1:INS_W] : '0;
    assign head_ins   = head_valid ? mem[rd_ptr][INS_W-1:0]            : INS_NOP;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: launches one memory request at a time from the PC,
// buffers returned words with their addresses, and drops everything on a redirect.
module ifetch
    import mycpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_adv,
    input  logic              flush_in,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc_out,
    output logic              ins_valid,
    input  logic              ins_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifetch_state_t    state;
    ifetch_state_t    state_nxt;
    logic [CNT_W-1:0] count;
    logic             has_room;
    logic             launch;
    logic             push;
    logic             pop;

    assign has_room = (count < CNT_W'(DEPTH));
    assign pop      = ins_valid && ins_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: a redirect while waiting keeps the request alive but marks it dead.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (has_room && !flush_in) state_nxt = REQ;
            REQ:     if (imem_ack)              state_nxt = IDLE;
                     else if (flush_in)         state_nxt = DRAIN;
            DRAIN:   if (imem_ack)              state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Per-state strobes: launch a fetch from IDLE, keep a response only from REQ.
    always_comb begin
        launch = 1'b0;
        push   = 1'b0;
        case (state)
            IDLE:    launch = has_room && !flush_in;
            REQ:     push   = imem_ack && !flush_in;
            default: ;
        endcase
    end

    // Memory-side registers: request held until ack, address captured at launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req  <= 1'b0;
            imem_addr <= '0;
            pc_adv    <= 1'b0;
        end else begin
            imem_req <= (state_nxt != IDLE);
            pc_adv   <= launch;
            if (launch) imem_addr <= pc_in;
        end
    end

    ifetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_in),
        .push      (push),
        .pop       (pop),
        .push_pc   (imem_addr),
        .push_ins  (imem_rdata),
        .count     (count),
        .head_ins  (ins_out),
        .head_pc   (ins_pc_out),
        .head_valid(ins_valid)
    );

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios followed by a randomized run checked
// against an in-order address-stream model of what the decoder should receive.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_in;
    logic        pc_adv;
    logic        flush_in = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ins_out;
    logic [15:0] ins_pc_out;
    logic        ins_valid;
    logic        ins_ready = 1'b0;

    // Program counter model
    logic [15:0] pc;
    logic        pc_load = 1'b1;
    logic [15:0] pc_load_val = 16'h0000;

    // Memory model
    logic        mem_en = 1'b1;
    logic        man_ack = 1'b0;
    logic [15:0] man_data = 16'h0000;
    int          lat = 0;
    int          wait_cnt;
    int          adv_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .pc_adv    (pc_adv),
        .flush_in  (flush_in),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ins_out   (ins_out),
        .ins_pc_out(ins_pc_out),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return (a ^ 16'h3C5A) + {a[7:0], a[15:8]} + 16'h0101;
    endfunction

    assign pc_in = pc;

    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (pc_adv) pc <= pc + 16'd1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    assign imem_ack   = mem_en ? (imem_req && (wait_cnt == lat)) : man_ack;
    assign imem_rdata = mem_en ? word(imem_addr) : man_data;

    always @(negedge clk) begin
        if (pc_adv === 1'b1) adv_cnt <= adv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_hold(input logic [15:0] start);
        rst = 1'b1;
        pc_load = 1'b1;
        pc_load_val = start;
        flush_in = 1'b0;
        ins_ready = 1'b0;
        mem_en = 1'b1;
        man_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_rst();
        rst = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (ins_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, ins_valid}, 32'd1);
    endtask

    initial begin
        int          a0;
        logic [15:0] exp_next;
        logic [15:0] tgt;
        logic [15:0] prev_addr;
        logic        prev_req;
        logic        prev_ack;
        logic        do_flush;
        int          pops;

        // ---- reset values, first fetch with zero-latency memory ----
        lat = 0;
        reset_hold(16'h0010);
        chk("rst_req",    {31'd0, imem_req},  32'd0);
        chk("rst_addr",   {16'd0, imem_addr}, 32'd0);
        chk("rst_adv",    {31'd0, pc_adv},    32'd0);
        chk("rst_valid",  {31'd0, ins_valid}, 32'd0);
        chk("rst_ins",    {16'd0, ins_out},   32'd0);
        chk("rst_inspc",  {16'd0, ins_pc_out},32'd0);
        a0 = adv_cnt;
        release_rst();
        tick();
        chk("k0_req",     {31'd0, imem_req},  32'd1);
        chk("k0_adv",     {31'd0, pc_adv},    32'd1);
        chk("k0_addr",    {16'd0, imem_addr}, 32'h0010);
        chk("k0_novalid", {31'd0, ins_valid}, 32'd0);
        tick();
        chk("k0_valid",   {31'd0, ins_valid}, 32'd1);
        chk("k0_ins",     {16'd0, ins_out},   {16'd0, word(16'h0010)});
        chk("k0_inspc",   {16'd0, ins_pc_out},32'h0010);
        chk("k0_req_lo",  {31'd0, imem_req},  32'd0);
        chk("k0_adv_lo",  {31'd0, pc_adv},    32'd0);

        // ---- FIFO full stalls fetching ----
        repeat (6) tick();
        chk("full_adv_cnt", adv_cnt - a0, 32'd2);
        chk("full_req",     {31'd0, imem_req},  32'd0);
        chk("full_head",    {16'd0, ins_pc_out},32'h0010);

        // ---- pops in order, then fetching restarts ----
        ins_ready = 1'b1;
        tick();
        chk("pop1_pc",  {16'd0, ins_pc_out}, 32'h0011);
        chk("pop1_ins", {16'd0, ins_out},    {16'd0, word(16'h0011)});
        chk("pop1_req", {31'd0, imem_req},   32'd0);
        tick();
        chk("pop2_valid", {31'd0, ins_valid}, 32'd0);
        chk("pop2_nop",   {16'd0, ins_out},   32'd0);
        chk("pop2_pc0",   {16'd0, ins_pc_out},32'd0);
        chk("restart_req",  {31'd0, imem_req},  32'd1);
        chk("restart_addr", {16'd0, imem_addr}, 32'h0012);
        ins_ready = 1'b0;
        tick();
        chk("buf12_pc", {16'd0, ins_pc_out}, 32'h0012);
        tick();
        chk("launch13_req", {31'd0, imem_req}, 32'd1);

        // ---- simultaneous push and pop at count 1 ----
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("pp_valid", {31'd0, ins_valid}, 32'd1);
        chk("pp_pc",    {16'd0, ins_pc_out},32'h0013);
        chk("pp_ins",   {16'd0, ins_out},   {16'd0, word(16'h0013)});
        tick();
        chk("pp_launch", {31'd0, imem_req}, 32'd1);
        tick();
        tick();
        chk("pp_full_req", {31'd0, imem_req}, 32'd0);

        // ---- flush in the same cycle as ack, one entry buffered ----
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        lat = 1;
        chk("fa_head", {16'd0, ins_pc_out}, 32'h0014);
        tick();
        chk("fa_req", {31'd0, imem_req}, 32'd1);
        chk("fa_noack", {31'd0, imem_ack}, 32'd0);
        tick();
        chk("fa_ack", {31'd0, imem_ack}, 32'd1);
        flush_in = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0100;
        tick();
        flush_in = 1'b0;
        pc_load = 1'b0;
        chk("fa_valid", {31'd0, ins_valid}, 32'd0);
        chk("fa_req_lo",{31'd0, imem_req},  32'd0);
        chk("fa_adv",   {31'd0, pc_adv},    32'd0);
        chk("fa_inspc", {16'd0, ins_pc_out},32'd0);
        tick();
        chk("fa_next_req",  {31'd0, imem_req},  32'd1);
        chk("fa_next_addr", {16'd0, imem_addr}, 32'h0100);
        chk("fa_next_adv",  {31'd0, pc_adv},    32'd1);

        // ---- k=3 latency with a flush while the request is outstanding ----
        lat = 3;
        reset_hold(16'h0080);
        release_rst();
        tick();
        chk("dr_req", {31'd0, imem_req}, 32'd1);
        flush_in = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0200;
        tick();
        flush_in = 1'b0;
        pc_load = 1'b0;
        chk("dr_hold_req",  {31'd0, imem_req},  32'd1);
        chk("dr_hold_addr", {16'd0, imem_addr}, 32'h0080);
        chk("dr_no_adv",    {31'd0, pc_adv},    32'd0);
        tick();
        chk("dr_hold_req2", {31'd0, imem_req}, 32'd1);
        tick();
        chk("dr_ack", {31'd0, imem_ack & imem_req}, 32'd1);
        tick();
        chk("dr_done_req",  {31'd0, imem_req},  32'd0);
        chk("dr_dropped",   {31'd0, ins_valid}, 32'd0);
        tick();
        chk("dr_new_req",  {31'd0, imem_req},  32'd1);
        chk("dr_new_addr", {16'd0, imem_addr}, 32'h0200);
        chk("dr_new_adv",  {31'd0, pc_adv},    32'd1);
        wait_valid("dr_wait", 10);
        chk("dr_head_pc",  {16'd0, ins_pc_out}, 32'h0200);
        chk("dr_head_ins", {16'd0, ins_out},    {16'd0, word(16'h0200)});

        // ---- pointer wrap and address wrap over six fetches ----
        lat = 0;
        reset_hold(16'hFFFE);
        ins_ready = 1'b1;
        release_rst();
        exp_next = 16'hFFFE;
        for (int i = 0; i < 6; i++) begin
            wait_valid("wrap_wait", 10);
            chk("wrap_pc",  {16'd0, ins_pc_out}, {16'd0, exp_next});
            chk("wrap_ins", {16'd0, ins_out},    {16'd0, word(exp_next)});
            exp_next = exp_next + 16'd1;
            tick();
        end
        ins_ready = 1'b0;

        // ---- asynchronous reset in the middle of a request ----
        lat = 0;
        reset_hold(16'h0300);
        release_rst();
        tick();
        tick();
        lat = 3;
        tick();
        chk("ar_req_pre",   {31'd0, imem_req},  32'd1);
        chk("ar_valid_pre", {31'd0, ins_valid}, 32'd1);
        rst = 1'b1;
        #2;
        chk("ar_req",   {31'd0, imem_req},  32'd0);
        chk("ar_addr",  {16'd0, imem_addr}, 32'd0);
        chk("ar_adv",   {31'd0, pc_adv},    32'd0);
        chk("ar_valid", {31'd0, ins_valid}, 32'd0);
        chk("ar_ins",   {16'd0, ins_out},   32'd0);
        chk("ar_inspc", {16'd0, ins_pc_out},32'd0);

        // ---- stray ack while idle with a full buffer is ignored ----
        lat = 0;
        reset_hold(16'h0300);
        release_rst();
        repeat (8) tick();
        mem_en = 1'b0;
        man_ack = 1'b1;
        man_data = 16'hBEEF;
        repeat (3) tick();
        chk("ig_req",  {31'd0, imem_req},   32'd0);
        chk("ig_pc",   {16'd0, ins_pc_out}, 32'h0300);
        chk("ig_ins",  {16'd0, ins_out},    {16'd0, word(16'h0300)});
        man_ack = 1'b0;
        mem_en = 1'b1;
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("ig_pc2",  {16'd0, ins_pc_out}, 32'h0301);
        chk("ig_ins2", {16'd0, ins_out},    {16'd0, word(16'h0301)});

        // ---- randomized traffic against the in-order stream model ----
        exp_next = 16'($urandom);
        lat = 0;
        reset_hold(exp_next);
        release_rst();
        pops = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            if (imem_req && prev_req && !prev_ack)
                chk("rnd_addr_stable", {16'd0, imem_addr}, {16'd0, prev_addr});
            do_flush  = ($urandom_range(0, 24) == 0);
            ins_ready = 1'($urandom_range(0, 1));
            if (do_flush) begin
                tgt = 16'($urandom);
                flush_in = 1'b1;
                pc_load = 1'b1;
                pc_load_val = tgt;
                exp_next = tgt;
            end else begin
                flush_in = 1'b0;
                pc_load = 1'b0;
                if (ins_valid && ins_ready) begin
                    chk("rnd_pc",  {16'd0, ins_pc_out}, {16'd0, exp_next});
                    chk("rnd_ins", {16'd0, ins_out},    {16'd0, word(exp_next)});
                    exp_next = exp_next + 16'd1;
                    pops++;
                end
            end
            if (!imem_req) lat = $urandom_range(0, 3);
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            tick();
        end
        flush_in = 1'b0;
        pc_load = 1'b0;
        chk("rnd_progress", {31'd0, pops >= 100}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
